// File: rtl/bcd_check_tx_pkg.sv
// Shared types and helpers for the BCD mod-3 check-digit transmitter.
package bcd_check_tx_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SEND  = 2'd1;
  localparam state_t CHECK = 2'd2;

  typedef logic [1:0] residue_t;

  // MOD3_CHECK map: digit that brings a running residue back to 0.
  function automatic residue_t mod3_check(input residue_t r);
    case (r)
      2'd1:    return 2'd2;
      2'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic residue_t mod3_add(input residue_t a, input residue_t b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? residue_t'(s - 3'd3) : s[1:0];
  endfunction

endpackage

// File: rtl/bcd_check_tx_nibble_mod3.sv
// Combinational residue (mod 3) of a 4-bit code; covers all 16 codes, not just BCD.
module nibble_mod3
  import bcd_check_tx_pkg::*;
(
  input  logic [3:0] nibble,
  output residue_t   residue
);

  always_comb begin
    residue = 2'd0;
    unique case (nibble)
      4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: residue = 2'd0;
      4'd1, 4'd4, 4'd7, 4'd10, 4'd13:       residue = 2'd1;
      4'd2, 4'd5, 4'd8, 4'd11, 4'd14:       residue = 2'd2;
      default:                              residue = 2'd0;
    endcase
  end

endmodule

// File: rtl/bcd_check_tx.sv
// Serialises a BCD word MSD first, one nibble per handshake, then appends a
// check digit that makes the digit sum (and hence the stream value) divisible by 3.
module bcd_check_tx
  import bcd_check_tx_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] value,
  output logic [3:0]          digit,
  output logic                digit_valid,
  input  logic                digit_ready,
  output logic                last,
  output logic                busy,
  output logic                bad_digit
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t           state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  residue_t         residue_q, residue_d;
  residue_t         nib_res, res_sum;
  logic [3:0]       digit_d;
  logic             valid_d, last_d, busy_d, bad_d;
  logic             load_bad;
  logic             fire;

  nibble_mod3 u_nibble_mod3 (
    .nibble  (shift_q[W-1 -: 4]),
    .residue (nib_res)
  );

  assign fire    = digit_valid && digit_ready;
  assign res_sum = mod3_add(residue_q, nib_res);

  always_comb begin
    load_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (value[4*i +: 4] > 4'd9) load_bad = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    residue_d = residue_q;
    digit_d   = digit;
    valid_d   = digit_valid;
    last_d    = last;
    busy_d    = busy;
    bad_d     = bad_digit;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND;
          shift_d   = value;
          cnt_d     = CNT_W'(DIGITS - 1);
          residue_d = 2'd0;
          digit_d   = value[W-1 -: 4];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          last_d    = 1'b0;
          bad_d     = load_bad;
        end
      end
      SEND: begin
        if (fire) begin
          residue_d = res_sum;
          shift_d   = shift_q << 4;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = CHECK;
            cnt_d   = '0;
            digit_d = {2'b00, mod3_check(res_sum)};
            last_d  = 1'b1;
          end else begin
            digit_d = shift_d[W-1 -: 4];
          end
        end
      end
      CHECK: begin
        if (fire) begin
          state_d = IDLE;
          digit_d = 4'd0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      residue_q   <= 2'd0;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      last        <= 1'b0;
      busy        <= 1'b0;
      bad_digit   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      residue_q   <= residue_d;
      digit       <= digit_d;
      digit_valid <= valid_d;
      last        <= last_d;
      busy        <= busy_d;
      bad_digit   <= bad_d;
    end
  end

endmodule

// File: doc/bcd_check_tx.md
# bcd_check_tx

Transmit side of the team's digit-stream divisibility-by-3 scheme. Loads a parallel `DIGITS`-digit BCD word, sends it one nibble per handshake, most significant digit first, then appends one check digit (0, 1 or 2) so the whole transmitted stream is divisible by 3. The stream feeds `seqdiv`, or any consumer that keeps a running residue mod 3.

## Interface
- `DIGITS`, default 4: number of BCD digits in `value`; legal range ≥ 1.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `start` in 1: load request; sampled only in IDLE.
- `value` in 4*DIGITS: word to send; nibble `DIGITS-1` is the MSD; sampled only on an accepted `start`.
- `digit` out 4: current nibble.
- `digit_valid` out 1: `digit` is presented.
- `digit_ready` in 1: consumer accepts; a beat transfers when valid && ready.
- `last` out 1: high only while the check digit is presented.
- `busy` out 1: high outside IDLE.
- `bad_digit` out 1: sticky; some loaded nibble was > 9.

## Operation
- FSM states:
  - IDLE: `start` → SEND; loads the shift register, clears the residue, sets the beat counter to `DIGITS-1`, sets `bad_digit` = OR(nibble > 9) and clears it otherwise.
  - SEND: on each handshake, residue ← (residue + nibble mod 3) mod 3; shift left by one nibble; decrement the counter. The handshake on the counter-0 beat → CHECK.
  - CHECK: `digit` = (3 − residue) mod 3, zero-extended to 4 bits; `last` = 1; handshake → IDLE.
- Residue is a 2-bit register, always 0..2. The nibble residue is the full 0..15 mod 3 mapping, so invalid nibbles are still sent as-is and still enter the checksum.
- Correctness: 10 ≡ 1 (mod 3), so the stream value ≡ sum of digits. The appended digit makes that sum ≡ 0.
- `start` in SEND/CHECK is ignored and has no side effects; `value` changes outside the load cycle are ignored.
- Without a handshake, `digit`, `digit_valid`, `last` and internal state hold. `digit_valid` never drops before its handshake.
- Any `reset_n` low, including mid-frame, goes immediately to IDLE. The frame is abandoned, not resumed.

## Timing
- All outputs are registered.
- Reset values: `digit`=0, `digit_valid`=0, `last`=0, `busy`=0, `bad_digit`=0, residue=0, counter=0.
- `start` accepted at edge T → `busy`, `digit_valid` and the MSD visible after T; first possible transfer at edge T+1.
- With `digit_ready` held high, a frame is exactly `DIGITS+1` consecutive beats. The check-digit beat is the edge after the last data beat.
- After the final handshake: `digit_valid`, `last` and `busy` drop. A `start` present in the following cycle is accepted, so the minimum inter-frame gap is 1 idle cycle.
- `DIGITS`=1: one data beat, then the check beat.
- `digit_ready` may be high while `digit_valid` is low; nothing transfers.

## Structure
- Shared package holds:
  - state enum IDLE/SEND/CHECK (2-bit encoding);
  - a 2-bit residue type;
  - `MOD3_CHECK`: the 0→0, 1→2, 2→1 map.
- One natural sub-module, `nibble_mod3`: combinational 4-bit → 2-bit residue lookup covering all 16 codes. The top level holds the FSM, shift register, counter and residue accumulator.
- Bench pairing with `seqdiv`: drive its `BCD` with `digit` on handshake cycles and 0 otherwise (0 leaves the residue unchanged). Its `divisible` must be 1 in the cycle after the `last` handshake.

## Test plan
- `DIGITS`=4, `value`=16'h1234, ready held 1 → digits 1,2,3,4,2; `last` only on the 2; `seqdiv` reports divisible (12342 = 3·4114).
- `value`=16'h0000 → 0,0,0,0,0. `value`=16'h9999 → 9,9,9,9,0. `bad_digit`=0 for both.
- `value`=16'h1A00 → 1,A,0,0,1 with `bad_digit`=1; a following load of 16'h0003 clears `bad_digit`, sends 0,0,0,3,0.
- 16'h1234 with ready low for 3 cycles while digit 2 is presented → `digit`=2 and valid held steady, then the stream resumes 2,3,4,2 with no loss or duplication.
- `start` pulsed with `value`=16'h5555 during the SEND of 16'h1234 → ignored, stream unchanged; `start` in the cycle after the final handshake → accepted, frame begins after that edge.
- `reset_n` pulsed low after 2 beats of 16'h1234 → all outputs at reset values immediately; the next frame 16'h0007 → 0,0,0,7,2.
